mdu_hilo: RTL and testbench



---
 rtl/mdu_hilo_pkg.sv | 29 ++
 rtl/mdu_hilo_div_step.sv | 29 ++
 rtl/mdu_hilo.sv | 185 ++++++++++++++++++
 tb/tb_mdu_hilo.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - op codes as presented on the op port
//   - controller state encoding
//   - default datapath width
package mdu_hilo_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULTU = 3'd0,
        OP_MULT  = 3'd1,
        OP_DIVU  = 3'd2,
        OP_DIV   = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_hilo_div_step.sv
// mdu_hilo_div_step: one combinational restoring-division step.
// Ports:
//   rem_i      partial remainder (always < divisor, or dividend bits when divisor=0)
//   next_bit_i next dividend bit shifted into the remainder
//   divisor_i  divisor magnitude
//   rem_o      partial remainder after the trial subtract
//   q_bit_o    quotient bit produced by this step
module mdu_hilo_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             next_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, next_bit_i};
        diff    = shifted - {1'b0, divisor_i};
        // A borrow out of the extra bit means the divisor did not fit: restore.
        q_bit_o = ~diff[WIDTH];
        rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with HI/LO result registers.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-low reset
//   start  request, sampled only while busy=0
//   op     0=MULTU 1=MULT 2=DIVU 3=DIV 4=MTHI 5=MTLO 6,7=no-op
//   a, b   rs / rt operands
//   busy   multiply or divide in flight
//   done   one-cycle pulse when hi/lo carry a new mul/div result
//   hi, lo result registers
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO handled here
// S_MUL  | WIDTH shift-add steps on the 2*WIDTH accumulator
// S_DIV  | WIDTH restoring steps; acc = {remainder, dividend/quotient}
// S_FIX  | sign correction, write hi/lo, pulse done
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               sgn;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   div_rem;
    logic               div_qbit;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;

    assign sgn   = is_signed_op(op);
    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Multiplier sits in the low half and is consumed LSB first; the extra
    // sum bit keeps the carry of each partial add.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    mdu_hilo_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i      (acc_q[2*WIDTH-1:WIDTH]),
        .next_bit_i (acc_q[WIDTH-1]),
        .divisor_i  (opb_q),
        .rem_o      (div_rem),
        .q_bit_o    (div_qbit)
    );

    // With a zero divisor the restoring loop leaves |a| in the remainder, so
    // restoring the dividend sign reproduces the raw a bits for hi.
    assign prod_fixed = neg_res_q ? -acc_q : acc_q;
    assign quo_fixed  = dz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem_fixed  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        is_div_d  = is_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULTU, OP_MULT: begin
                            acc_d     = {{WIDTH{1'b0}}, b_mag};
                            opb_d     = a_mag;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = 1'b0;
                            dz_d      = 1'b0;
                            is_div_d  = 1'b0;
                            cnt_d     = '0;
                            state_d   = S_MUL;
                        end
                        OP_DIVU, OP_DIV: begin
                            acc_d     = {{WIDTH{1'b0}}, a_mag};
                            opb_d     = b_mag;
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            dz_d      = (b == '0);
                            is_div_d  = 1'b1;
                            cnt_d     = '0;
                            state_d   = S_DIV;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) state_d = S_FIX;
            end
            S_DIV: begin
                acc_d = {div_rem, acc_q[WIDTH-2:0], div_qbit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fixed;
                    lo_d = quo_fixed;
                end else begin
                    hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                    lo_d = prod_fixed[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            is_div_q  <= is_div_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
module tb_mdu_hilo;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'd0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mdu_hilo #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Architectural result of one op, from plain integer arithmetic.
    task automatic model_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int          sx, sy, sq, sr;
        longint      p;
        logic [63:0] up;
        sx = x;
        sy = y;
        case (o)
            3'd0: begin
                up   = 64'(x) * 64'(y);
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            3'd1: begin
                p    = longint'(sx) * longint'(sy);
                up   = p;
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            3'd2: begin
                if (y == 0) begin
                    m_lo = '1;
                    m_hi = x;
                end else begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
            3'd3: begin
                if (y == 0) begin
                    m_lo = '1;
                    m_hi = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = '0;
                end else begin
                    sq   = sx / sy;
                    sr   = sx % sy;
                    m_lo = sq;
                    m_hi = sr;
                end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    // Multiply/divide: busy length, hi/lo hold, done pulse and result.
    // With intrude set, MTHI and MULTU requests are pulsed mid-operation.
    task automatic run_long(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input bit intrude);
        int           cyc;
        bit           held;
        logic [W-1:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        model_op(o, x, y);
        @(negedge clock);
        start = 1'b0; a = $urandom; b = $urandom;
        cyc  = 0;
        held = 1'b1;
        while (busy && cyc < 100) begin
            cyc++;
            if (hi !== old_hi || lo !== old_lo || done !== 1'b0) held = 1'b0;
            if (intrude && cyc == 5) begin
                start = 1'b1; op = 3'd4; a = $urandom;
            end else if (intrude && cyc == 8) begin
                start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0;
        check({tag, " busy_len"}, 64'(cyc), 64'(W + 1));
        check({tag, " hold"}, 64'(held), 64'd1);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " hi"}, 64'(hi), 64'(m_hi));
        check({tag, " lo"}, 64'(lo), 64'(m_lo));
        @(negedge clock);
        check({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    // MTHI/MTLO/no-op: effect at the next edge, never busy or done.
    task automatic run_short(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                             input logic [W-1:0] y);
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        model_op(o, x, y);
        @(negedge clock);
        start = 1'b0; a = $urandom; b = $urandom;
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(m_hi));
        check({tag, " lo"}, 64'(lo), 64'(m_lo));
    endtask

    initial begin
        int           dones;
        logic [2:0]   ro;
        logic [W-1:0] rx, ry;

        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        reset = 1'b1;

        run_long("multu_max", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max hi_const", 64'(hi), 64'hFFFF_FFFE);
        check("multu_max lo_const", 64'(lo), 64'h0000_0001);
        run_long("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("mult_neg lo_const", 64'(lo), 64'hFFFF_FFEB);
        run_long("divu", 3'd2, 32'd100, 32'd7, 1'b0);
        check("divu lo_const", 64'(lo), 64'd14);
        run_long("div_neg_a", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_long("div_neg_b", 3'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
        check("div_neg_b hi_const", 64'(hi), 64'd1);
        run_long("div_by0", 3'd3, 32'h1234, 32'd0, 1'b0);
        run_long("div_by0_neg", 3'd3, 32'h8765_4321, 32'd0, 1'b0);
        run_long("divu_by0", 3'd2, 32'hDEAD_BEEF, 32'd0, 1'b0);
        run_long("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf lo_const", 64'(lo), 64'h8000_0000);

        run_short("mtlo", 3'd5, 32'hCAFE_BABE, 32'd0);
        run_short("mthi", 3'd4, 32'h1357_9BDF, 32'd0);
        run_short("nop6", 3'd6, 32'h1111_1111, 32'h2222_2222);
        run_short("nop7", 3'd7, 32'h3333_3333, 32'h4444_4444);

        run_long("divu_intrude", 3'd2, 32'd1_000_003, 32'd97, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            case ($urandom_range(0, 5))
                0:       ry = '0;
                1:       ry = 32'($urandom_range(1, 15));
                2:       ry = 32'hFFFF_FFFF;
                default: ry = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) rx = 32'($urandom_range(0, 255));
            if (ro <= 3'd3) run_long($sformatf("rnd%0d_op%0d", i, ro), ro, rx, ry, 1'b0);
            else            run_short($sformatf("rnd%0d_op%0d", i, ro), ro, rx, ry);
        end

        // Reset in the middle of a divide discards it entirely.
        @(negedge clock);
        start = 1'b1; op = 3'd2; a = 32'd12345; b = 32'd67;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        check("midrst pre busy", 64'(busy), 64'd1);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        check("midrst hi", 64'(hi), 64'd0);
        check("midrst lo", 64'(lo), 64'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        check("midrst no_done", 64'(dones), 64'd0);
        check("midrst hi_after", 64'(hi), 64'd0);

        run_long("post_rst_mult", 3'd1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
